qdec_ctx_mem: RTL and testbench

Context-model state memory for the CABAC decoder. Receives the write stream produced by the context-init sub-FSM (address / 7-bit state / write-enable, then a done pulse) and serves the arithmetic bin decoder with 1-cycle reads and same-cycle-visible updates. Sits between qdec_ctx_init and the bin-decode engine under the CABAC top.

---
 rtl/qdec_ctx_mem.sv | 210 +++++++++++++++++++++
 tb/tb_qdec_ctx_mem.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdec_ctx_mem.sv
// CABAC context-state memory: init write stream, 1-cycle decoder reads, write-first updates.
// Optional WPP shadow bank (save/restore copy engine) enabled by defining QDEC_CTX_WPP_SYNC_EN.
module qdec_ctx_mem #(
    parameter int NUM_CTX = 566,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctx_init_start,
    input  logic [ADDR_W-1:0] ctx_init_addr,
    input  logic [DATA_W-1:0] ctx_init_wdata,
    input  logic              ctx_init_we,
    input  logic              ctx_init_done_intr,
    output logic              ctx_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-2:0] rd_state,
    output logic              rd_mps,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-2:0] upd_state,
    input  logic              upd_mps,
    output logic              err_access,
    input  logic              sync_save,
    input  logic              sync_restore,
    output logic              sync_busy
);

    localparam logic [ADDR_W-1:0] LP_NUM = ADDR_W'(NUM_CTX);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_READY   = 3'd2,
        S_SAVE    = 3'd3,
        S_RESTORE = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_rd_valid;
    logic [DATA_W-2:0] r_rd_state;
    logic              r_rd_mps;
    logic              r_err;

    logic [DATA_W-1:0] r_mem [NUM_CTX];

    logic              w_in_ready;
    logic              w_rd_acc;
    logic              w_rd_in_range;
    logic              w_upd_wr;
    logic              w_init_wr;
    logic              w_err_evt;
    logic [DATA_W-1:0] w_rd_word;

`ifdef QDEC_CTX_WPP_SYNC_EN
    logic [DATA_W-1:0] r_shadow [NUM_CTX];
    logic [ADDR_W-1:0] r_cp_cnt;
    logic [DATA_W-1:0] r_cp_data;
    logic              r_busy;
    logic [ADDR_W-1:0] w_cp_waddr;
    logic              w_save_wr;
    logic              w_restore_wr;
`else
    logic              w_unused_sync;
    assign w_unused_sync = sync_save | sync_restore;
`endif

    // ctx_init_start dominates every other request in its cycle.
    always_comb begin
        w_in_ready    = (r_state == S_READY) && !ctx_init_start;
        w_rd_acc      = rd_en && w_in_ready;
        w_rd_in_range = (rd_addr < LP_NUM);
        w_upd_wr      = upd_en && w_in_ready && (upd_addr < LP_NUM);
        w_init_wr     = ctx_init_we && (r_state == S_INIT) && (ctx_init_addr < LP_NUM);
        w_err_evt     = (ctx_init_we && (r_state == S_INIT) && !(ctx_init_addr < LP_NUM))
                      | (rd_en  && ((r_state != S_READY) || !w_rd_in_range))
                      | (upd_en && ((r_state != S_READY) || !(upd_addr < LP_NUM)));
    end

    // Write-first: an update to the address being read in the same cycle is forwarded.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            if (w_upd_wr && (upd_addr == rd_addr)) begin
                w_rd_word = {upd_mps, upd_state};
            end else begin
                w_rd_word = r_mem[rd_addr];
            end
        end
    end

`ifdef QDEC_CTX_WPP_SYNC_EN
    // Copy pipeline: entry k is read while cnt==k and written while cnt==k+1.
    always_comb begin
        w_cp_waddr   = r_cp_cnt - ADDR_W'(1);
        w_save_wr    = (r_state == S_SAVE)    && (r_cp_cnt != '0) && !ctx_init_start;
        w_restore_wr = (r_state == S_RESTORE) && (r_cp_cnt != '0) && !ctx_init_start;
    end

    always_ff @(posedge clk) begin
        if (w_save_wr) begin
            r_shadow[w_cp_waddr] <= r_cp_data;
        end
        if (r_cp_cnt < LP_NUM) begin
            r_cp_data <= (r_state == S_RESTORE) ? r_shadow[r_cp_cnt] : r_mem[r_cp_cnt];
        end
    end
`endif

    // Context RAM is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (w_init_wr) begin
            r_mem[ctx_init_addr] <= ctx_init_wdata;
        end else if (w_upd_wr) begin
            r_mem[upd_addr] <= {upd_mps, upd_state};
        end
`ifdef QDEC_CTX_WPP_SYNC_EN
        else if (w_restore_wr) begin
            r_mem[w_cp_waddr] <= r_cp_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_state <= '0;
            r_rd_mps   <= 1'b0;
            r_err      <= 1'b0;
`ifdef QDEC_CTX_WPP_SYNC_EN
            r_cp_cnt   <= '0;
            r_busy     <= 1'b0;
`endif
        end else begin
            r_rd_valid <= 1'b0;
            if (ctx_init_start) begin
                r_state <= S_INIT;
                r_ready <= 1'b0;
                r_err   <= 1'b0;
`ifdef QDEC_CTX_WPP_SYNC_EN
                r_busy  <= 1'b0;
`endif
            end else begin
                if (w_err_evt) begin
                    r_err <= 1'b1;
                end
                if (w_rd_acc) begin
                    r_rd_valid <= 1'b1;
                    r_rd_state <= w_rd_word[DATA_W-2:0];
                    r_rd_mps   <= w_rd_word[DATA_W-1];
                end
                case (r_state)
                    S_IDLE: begin
                        r_ready <= 1'b0;
                    end
                    S_INIT: begin
                        if (ctx_init_done_intr) begin
                            r_state <= S_READY;
                            r_ready <= 1'b1;
                        end
                    end
                    S_READY: begin
`ifdef QDEC_CTX_WPP_SYNC_EN
                        if (sync_save || sync_restore) begin
                            r_state  <= sync_save ? S_SAVE : S_RESTORE;
                            r_ready  <= 1'b0;
                            r_busy   <= 1'b1;
                            r_cp_cnt <= '0;
                        end
`else
                        r_ready <= 1'b1;
`endif
                    end
`ifdef QDEC_CTX_WPP_SYNC_EN
                    S_SAVE, S_RESTORE: begin
                        if (r_cp_cnt == LP_NUM) begin
                            r_state <= S_READY;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cp_cnt <= r_cp_cnt + ADDR_W'(1);
                        end
                    end
`endif
                    default: begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ctx_ready  = r_ready;
    assign rd_valid   = r_rd_valid;
    assign rd_state   = r_rd_state;
    assign rd_mps     = r_rd_mps;
    assign err_access = r_err;
`ifdef QDEC_CTX_WPP_SYNC_EN
    assign sync_busy  = r_busy;
`else
    assign sync_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_qdec_ctx_mem.sv
// Directed + randomized bench for qdec_ctx_mem against an array-based reference model.
module tb_qdec_ctx_mem;
  localparam int NUM_CTX = 566;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ctx_init_start = 1'b0;
  logic [ADDR_W-1:0] ctx_init_addr = '0;
  logic [DATA_W-1:0] ctx_init_wdata = '0;
  logic              ctx_init_we = 1'b0;
  logic              ctx_init_done_intr = 1'b0;
  logic              ctx_ready;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_valid;
  logic [5:0]        rd_state;
  logic              rd_mps;
  logic              upd_en = 1'b0;
  logic [ADDR_W-1:0] upd_addr = '0;
  logic [5:0]        upd_state = '0;
  logic              upd_mps = 1'b0;
  logic              err_access;
  logic              sync_save = 1'b0;
  logic              sync_restore = 1'b0;
  logic              sync_busy;

  always #5 clk = ~clk;

  qdec_ctx_mem #(.NUM_CTX(NUM_CTX), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctx_init_start(ctx_init_start), .ctx_init_addr(ctx_init_addr),
    .ctx_init_wdata(ctx_init_wdata), .ctx_init_we(ctx_init_we),
    .ctx_init_done_intr(ctx_init_done_intr), .ctx_ready(ctx_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_state(rd_state), .rd_mps(rd_mps),
    .upd_en(upd_en), .upd_addr(upd_addr), .upd_state(upd_state), .upd_mps(upd_mps),
    .err_access(err_access),
    .sync_save(sync_save), .sync_restore(sync_restore), .sync_busy(sync_busy)
  );

  int n_checks = 0;
  int n_err = 0;

  // Reference model: plain arrays holding {valMps, pStateIdx} per context.
  logic [6:0] ref_mem    [NUM_CTX];
  logic [6:0] ref_shadow [NUM_CTX];
  logic [5:0] last_state = '0;
  logic       last_mps = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ctx_init_start = 1'b1;
    cyc();
    ctx_init_start = 1'b0;
  endtask

  task automatic run_init(input int n, input bit rnd);
    for (int a = 0; a < n; a++) begin
      logic [6:0] d;
      d = rnd ? 7'($urandom) : 7'(a);
      ctx_init_we = 1'b1;
      ctx_init_addr = 10'(a);
      ctx_init_wdata = d;
      ref_mem[a] = d;
      cyc();
    end
    ctx_init_we = 1'b0;
  endtask

  task automatic pulse_done();
    ctx_init_done_intr = 1'b1;
    cyc();
    ctx_init_done_intr = 1'b0;
  endtask

  task automatic do_read(input int a, input string tag);
    logic [6:0] e;
    e = (a < NUM_CTX) ? ref_mem[a] : 7'd0;
    rd_en = 1'b1;
    rd_addr = 10'(a);
    cyc();
    rd_en = 1'b0;
    last_state = e[5:0];
    last_mps = e[6];
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_state"}, 32'(rd_state), 32'(e[5:0]));
    check({tag, "_mps"}, 32'(rd_mps), 32'(e[6]));
  endtask

  task automatic rand_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      bit re;
      bit ue;
      int ra;
      int ua;
      logic [6:0] ud;
      re = 1'($urandom_range(0, 1));
      ue = ($urandom_range(0, 2) == 0);
      ra = $urandom_range(0, NUM_CTX - 1);
      ua = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, NUM_CTX - 1);
      ud = 7'($urandom);
      rd_en = re; rd_addr = 10'(ra);
      upd_en = ue; upd_addr = 10'(ua); upd_state = ud[5:0]; upd_mps = ud[6];
      if (ue) ref_mem[ua] = ud;
      if (re) begin
        last_state = ref_mem[ra][5:0];
        last_mps = ref_mem[ra][6];
      end
      cyc();
      check("traffic_valid", 32'(rd_valid), 32'(re));
      check("traffic_state", 32'(rd_state), 32'(last_state));
      check("traffic_mps", 32'(rd_mps), 32'(last_mps));
    end
    rd_en = 1'b0;
    upd_en = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (sync_busy === 1'b1 && n < 2000) begin
      n++;
      cyc();
    end
    check(tag, 32'(n), 32'(NUM_CTX + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) cyc();
    check("rst_ready", 32'(ctx_ready), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_state", 32'(rd_state), 32'd0);
    check("rst_mps", 32'(rd_mps), 32'd0);
    check("rst_err", 32'(err_access), 32'd0);
    check("rst_busy", 32'(sync_busy), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Full init with data = addr[6:0]
    pulse_start();
    check("init_not_ready", 32'(ctx_ready), 32'd0);
    run_init(NUM_CTX, 1'b0);
    check("pre_done_ready", 32'(ctx_ready), 32'd0);
    pulse_done();
    check("post_done_ready", 32'(ctx_ready), 32'd1);
    do_read(0, "rd0");
    do_read(100, "rd100");
    do_read(565, "rd565");
    cyc();
    check("idle_valid", 32'(rd_valid), 32'd0);
    check("idle_hold_state", 32'(rd_state), 32'(last_state));

    // Write-first forwarding on address 7
    rd_en = 1'b1; rd_addr = 10'd7;
    upd_en = 1'b1; upd_addr = 10'd7; upd_state = 6'd20; upd_mps = 1'b1;
    ref_mem[7] = {1'b1, 6'd20};
    cyc();
    rd_en = 1'b0; upd_en = 1'b0;
    last_state = 6'd20; last_mps = 1'b1;
    check("fwd_valid", 32'(rd_valid), 32'd1);
    check("fwd_state", 32'(rd_state), 32'd20);
    check("fwd_mps", 32'(rd_mps), 32'd1);
    do_read(7, "after_fwd");

    // Init strobe outside INIT must be ignored
    ctx_init_we = 1'b1; ctx_init_addr = 10'd5; ctx_init_wdata = 7'h7f;
    cyc();
    ctx_init_we = 1'b0;
    do_read(5, "we_ignored");

    rand_traffic(200);
    check("traffic_err", 32'(err_access), 32'd0);

    // WPP save / update / restore
    for (int a = 0; a < NUM_CTX; a++) ref_shadow[a] = ref_mem[a];
    sync_save = 1'b1;
    cyc();
    sync_save = 1'b0;
`ifdef QDEC_CTX_WPP_SYNC_EN
    check("save_busy", 32'(sync_busy), 32'd1);
    check("save_not_ready", 32'(ctx_ready), 32'd0);
    wait_busy("save_len");
    check("save_ready_after", 32'(ctx_ready), 32'd1);
`else
    check("save_busy_off", 32'(sync_busy), 32'd0);
    check("save_ready_off", 32'(ctx_ready), 32'd1);
`endif
    upd_en = 1'b1; upd_addr = 10'd3; upd_state = 6'd5; upd_mps = 1'b0;
    ref_mem[3] = {1'b0, 6'd5};
    cyc();
    upd_en = 1'b0;
    sync_restore = 1'b1;
    cyc();
    sync_restore = 1'b0;
`ifdef QDEC_CTX_WPP_SYNC_EN
    for (int a = 0; a < NUM_CTX; a++) ref_mem[a] = ref_shadow[a];
    check("restore_busy", 32'(sync_busy), 32'd1);
    wait_busy("restore_len");
    check("restore_ready_after", 32'(ctx_ready), 32'd1);
`else
    check("restore_busy_off", 32'(sync_busy), 32'd0);
`endif
    do_read(3, "rd3_after_restore");
    for (int i = 0; i < 8; i++) do_read($urandom_range(0, NUM_CTX - 1), "post_sync_rd");
    check("sync_err", 32'(err_access), 32'd0);

    // Out-of-range read and update
    do_read(600, "oob_rd");
    check("oob_err", 32'(err_access), 32'd1);
    upd_en = 1'b1; upd_addr = 10'd600; upd_state = 6'd9; upd_mps = 1'b1;
    cyc();
    upd_en = 1'b0;
    check("err_sticky", 32'(err_access), 32'd1);

    // Restart from READY; reads dropped until done
    pulse_start();
    check("restart_ready", 32'(ctx_ready), 32'd0);
    check("restart_err_clr", 32'(err_access), 32'd0);
    rd_en = 1'b1; rd_addr = 10'd10;
    cyc();
    rd_en = 1'b0;
    check("init_rd_valid", 32'(rd_valid), 32'd0);
    check("init_rd_hold", 32'(rd_state), 32'(last_state));
    check("init_rd_err", 32'(err_access), 32'd1);

    // Asynchronous reset in the middle of init
    run_init(200, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    last_state = '0; last_mps = 1'b0;
    check("arst_ready", 32'(ctx_ready), 32'd0);
    check("arst_valid", 32'(rd_valid), 32'd0);
    check("arst_state", 32'(rd_state), 32'd0);
    check("arst_mps", 32'(rd_mps), 32'd0);
    check("arst_err", 32'(err_access), 32'd0);
    check("arst_busy", 32'(sync_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Start and done together: start wins
    pulse_start();
    ctx_init_start = 1'b1; ctx_init_done_intr = 1'b1;
    cyc();
    ctx_init_start = 1'b0; ctx_init_done_intr = 1'b0;
    check("start_wins", 32'(ctx_ready), 32'd0);
    rd_en = 1'b1; rd_addr = 10'd1;
    cyc();
    rd_en = 1'b0;
    check("pre_done_rd_valid", 32'(rd_valid), 32'd0);
    check("pre_done_rd_err", 32'(err_access), 32'd1);

    // Fresh random init, one out-of-range init write, then verify
    pulse_start();
    check("reinit_err_clr", 32'(err_access), 32'd0);
    run_init(NUM_CTX, 1'b1);
    ctx_init_we = 1'b1; ctx_init_addr = 10'd700; ctx_init_wdata = 7'h11;
    cyc();
    ctx_init_we = 1'b0;
    check("oob_init_err", 32'(err_access), 32'd1);
    pulse_done();
    check("reinit_ready", 32'(ctx_ready), 32'd1);
    do_read(0, "reinit_rd0");
    do_read(565, "reinit_rd565");
    rand_traffic(150);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
